// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin arbiter sharing one FIFO write port, with occupancy
// tracking (in-flight write counted), flush/drain sequencing and a sticky underflow flag.
`default_nettype none

module fifo_push_arbiter #(
   parameter type T       = logic [31:0],
   parameter int  NUM_REQ = 4,
   parameter int  DEPTH   = 8,
   localparam int IW      = $clog2(NUM_REQ),
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_valid,
   input  T                   req_data [NUM_REQ],
   output logic [NUM_REQ-1:0] req_ready,
   input  logic               read_en,
   output logic               write_en,
   output T                   write_data,
   output logic [IW-1:0]      grant_id,
   output logic [CW-1:0]      count,
   input  logic               flush_req,
   output logic               flush_done,
   output logic               err_underflow
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   gnt;
   logic [IW-1:0]   idx;
   logic            found;
   logic            grant_en;
   logic            acc;
   logic            pop;
   logic [CW-1:0]   count_nxt;

   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign grant_en = rst_n && (state == RUN) && ((count < CW'(DEPTH)) || read_en);

   always_comb begin
      found     = 1'b0;
      gnt       = '0;
      idx       = '0;
      req_ready = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gnt   = idx;
         end
      end
      if (grant_en && found) begin
         req_ready[gnt] = 1'b1;
      end
   end

   assign acc       = |(req_valid & req_ready);
   assign pop       = read_en && (count != '0);
   assign count_nxt = count + CW'(acc) - CW'(pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         write_en      <= 1'b0;
         write_data    <= '0;
         grant_id      <= '0;
         count         <= '0;
         flush_done    <= 1'b0;
         err_underflow <= 1'b0;
         rr_ptr        <= IW'(NUM_REQ - 1);
         state         <= RUN;
      end else begin
         write_en   <= acc;
         flush_done <= 1'b0;
         count      <= count_nxt;
         if (acc) begin
            write_data <= req_data[gnt];
            grant_id   <= gnt;
            rr_ptr     <= gnt;
         end
         if (read_en && (count == '0)) begin
            err_underflow <= 1'b1;
         end
         case (state)
            RUN: begin
               if (flush_req) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (count_nxt == '0) begin
                  state      <= DONE;
                  flush_done <= 1'b1;
               end
            end
            DONE:    state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed scenarios plus random traffic, checked every cycle
// against a queue-free occupancy/priority model of the arbiter.
`default_nettype none

module tb_fifo_push_arbiter;

   localparam int NR = 4;
   localparam int DP = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] req_valid;
   logic [31:0]   req_data [NR];
   logic [NR-1:0] req_ready;
   logic          read_en;
   logic          write_en;
   logic [31:0]   write_data;
   logic [1:0]    grant_id;
   logic [3:0]    count;
   logic          flush_req;
   logic          flush_done;
   logic          err_underflow;

   int n_tests = 0;
   int n_fail  = 0;

   fifo_push_arbiter #(.T(logic [31:0]), .NUM_REQ(NR), .DEPTH(DP)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .read_en(read_en), .write_en(write_en),
      .write_data(write_data), .grant_id(grant_id), .count(count),
      .flush_req(flush_req), .flush_done(flush_done), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: occupancy as a plain integer, priority pointer as last winner.
   bit          m_init = 1'b0;
   int          m_cnt, m_rr, m_mode;   // mode 0 run, 1 draining, 2 drain finished
   bit          m_we, m_done, m_err;
   logic [31:0] m_wd;
   int          m_gid;

   function automatic int winner();
      if (!rst_n || m_mode != 0 || !(m_cnt < DP || read_en)) return -1;
      for (int i = 1; i <= NR; i++) begin
         if (req_valid[(m_rr + i) % NR]) return (m_rr + i) % NR;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      int  w, nc, nmode;
      bit  ndone;
      if (!rst_n) begin
         m_init <= 1'b1;
         m_cnt  <= 0;  m_rr  <= NR - 1; m_mode <= 0;
         m_we   <= 0;  m_wd  <= '0;     m_gid  <= 0;
         m_done <= 0;  m_err <= 0;
      end else if (m_init) begin
         w     = winner();
         nc    = m_cnt + ((w >= 0) ? 1 : 0) - ((read_en && m_cnt > 0) ? 1 : 0);
         nmode = m_mode;
         ndone = 1'b0;
         if (m_mode == 0 && flush_req) nmode = 1;
         else if (m_mode == 1 && nc == 0) begin nmode = 2; ndone = 1'b1; end
         else if (m_mode == 2) nmode = 0;
         m_we <= (w >= 0);
         if (w >= 0) begin
            m_wd  <= req_data[w];
            m_gid <= w;
            m_rr  <= w;
         end
         if (read_en && m_cnt == 0) m_err <= 1'b1;
         m_cnt  <= nc;
         m_mode <= nmode;
         m_done <= ndone;
      end
   end

   always @(negedge clk) begin
      int w;
      if (m_init) begin
         w = winner();
         chk("ready", req_ready, (w >= 0) ? (64'd1 << w) : 64'd0);
         chk("write_en", write_en, m_we);
         if (m_we) begin
            chk("write_data", write_data, m_wd);
            chk("grant_id", grant_id, m_gid);
         end
         chk("count", count, m_cnt);
         chk("flush_done", flush_done, m_done);
         chk("err_underflow", err_underflow, m_err);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit got;
      rst_n = 1'b0; req_valid = '0; read_en = 1'b0; flush_req = 1'b0;
      for (int i = 0; i < NR; i++) req_data[i] = '0;
      step(); step();
      chk("rst_count", count, 0);
      chk("rst_we", write_en, 0);
      chk("rst_err", err_underflow, 0);
      rst_n = 1'b1;
      req_valid = 4'hF; #1;
      chk("rst_first_prio", req_ready, 4'b0001);
      req_valid = '0;
      step();

      // Requester 2 alone fills the FIFO
      req_valid = 4'b0100;
      for (int k = 0; k < 8; k++) begin
         req_data[2] = k;
         step();
         chk("t1_gid", grant_id, 2);
         chk("t1_data", write_data, k);
      end
      chk("t1_full", count, 8);
      chk("t1_noready", req_ready, 0);

      // Full FIFO with a concurrent pop still grants
      req_valid = 4'b0010; req_data[1] = 32'hABCD; read_en = 1'b1; #1;
      chk("t3_ready", req_ready, 4'b0010);
      step();
      chk("t3_count", count, 8);
      chk("t3_gid", grant_id, 1);

      req_valid = '0;
      repeat (7) step();
      chk("t2_pre_count", count, 1);

      // All requesting, pop every cycle: rotation continues after last winner (1)
      req_valid = 4'hF;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("t2_gid", grant_id, (2 + i) % 4);
         chk("t2_count", count, 1);
      end

      read_en = 1'b0;
      repeat (4) step();
      chk("t4_pre_count", count, 5);

      // Flush with reads each cycle
      req_valid = '0; flush_req = 1'b1; read_en = 1'b1;
      step();
      req_valid = 4'hF;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         chk("t4_noready", req_ready, 0);
         step();
         if (flush_done) begin
            got = 1'b1;
            chk("t4_count0", count, 0);
            flush_req = 1'b0;
            read_en   = 1'b0;
         end
      end
      chk("t4_done_seen", got, 1);
      step();
      chk("t4_done_pulse", flush_done, 0);
      chk("t4_resume", req_ready, 4'b0100);
      req_valid = '0;
      step();

      // Pop with empty FIFO
      read_en = 1'b1;
      step();
      chk("t5_count", count, 0);
      chk("t5_err", err_underflow, 1);
      read_en = 1'b0;
      step();
      chk("t5_sticky", err_underflow, 1);

      // Random traffic including flushes
      for (int c = 0; c < 600; c++) begin
         req_valid = 4'($urandom);
         read_en   = ($urandom_range(0, 2) == 0);
         for (int i = 0; i < NR; i++) req_data[i] = $urandom;
         if (!flush_req && $urandom_range(0, 31) == 0) flush_req = 1'b1;
         step();
         if (flush_done) flush_req = 1'b0;
      end

      // Reset mid-burst at count 3
      flush_req = 1'b0; read_en = 1'b0; req_valid = '0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req_valid = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         req_data[0] = 32'h100 + k;
         step();
      end
      chk("t6_pre_count", count, 3);
      rst_n = 1'b0;
      step();
      chk("t6_we", write_en, 0);
      chk("t6_count", count, 0);
      chk("t6_err", err_underflow, 0);
      chk("t6_data", write_data, 0);
      chk("t6_gid", grant_id, 0);
      rst_n = 1'b1;
      req_valid = 4'hF; #1;
      chk("t6_ready", req_ready, 4'b0001);
      step();
      chk("t6_next_gid", grant_id, 0);
      req_valid = '0;
      step(); step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

endmodule

`default_nettype wire
